// File: rtl/acc_max_stream.sv
// acc_max_stream: buffers each row group, finds its signed max, re-emits the rows paired with that max.
// Latency: the last row of a group (or a bypass row) accepted at edge t is presented in cycle t+1.
// Backpressure: o_ready drops while either FIFO is full; rows leave only on o_valid & i_ready.

// Small first-word-fall-through FIFO; the head entry is readable combinationally.
module acc_max_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push_vld & ~full;
  assign do_pop   = pop_rdy & ~empty;
  assign head_dat = mem[rd_ptr];

  // Pointer and occupancy tracking; a pop never makes room for a push in the same cycle
  // because callers gate their push on the registered full flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty, so no reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module acc_max_stream #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 64,
  parameter int MODE_W    = 4,
  parameter int ROW_DEPTH = 16,
  parameter int GRP_DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_W-1:0]       i_max,
  input  logic [MODE_W-1:0]       i_length_mode,
  input  logic [LANES*DATA_W-1:0] i_in_flat,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_W-1:0]       o_max,
  output logic [MODE_W-1:0]       o_length_mode_byp,
  output logic [LANES*DATA_W-1:0] o_in_byp,
  output logic                    o_last,
  output logic                    o_err_mode
);
  localparam int LW = LANES * DATA_W;
  localparam int RW = LW + MODE_W + 1;   // {data, latched mode, last flag}

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  acc;
  logic [MODE_W-1:0]         cnt;
  logic [MODE_W-1:0]         mode_lat;
  logic                      err_q;
  logic                      rst_q;

  logic signed [DATA_W-1:0]  max_s;
  logic signed [DATA_W-1:0]  acc_nxt;
  logic [MODE_W-1:0]         mode_eff;
  logic [MODE_W-1:0]         n_eff;
  logic [MODE_W-1:0]         cnt_nxt;
  logic                      row_last;

  logic                      in_acc;
  logic                      out_pop;
  logic                      row_full;
  logic                      row_empty;
  logic                      grp_full;
  logic                      grp_empty;
  logic [RW-1:0]             row_head;
  logic [DATA_W-1:0]         grp_head;

  assign max_s   = i_max;
  // Hold off intake for the cycle following a reset edge as well as while reset is held.
  assign o_ready = i_en & ~i_rst & ~rst_q & ~row_full & ~grp_full;
  assign in_acc  = i_en & i_valid & o_ready;
  assign o_valid = i_en & ~row_empty & ~grp_empty;
  assign out_pop = o_valid & i_ready;

  // Next accumulator/count values for an accepted row; an IDLE accept opens a new group
  // using the incoming mode, later rows of the group use the latched mode.
  always_comb begin
    mode_eff = mode_lat;
    cnt_nxt  = cnt + MODE_W'(1);
    acc_nxt  = (max_s > acc) ? max_s : acc;
    if (state == ST_IDLE) begin
      mode_eff = i_length_mode;
      cnt_nxt  = MODE_W'(1);
      acc_nxt  = max_s;
    end
    n_eff    = (mode_eff <= MODE_W'(2)) ? MODE_W'(1) : mode_eff - MODE_W'(1);
    row_last = (cnt_nxt == n_eff);
  end

  // Group FSM: tracks running max and row count, latches the group mode, flags mode mismatches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      cnt      <= '0;
      mode_lat <= '0;
      err_q    <= 1'b0;
    end else if (in_acc) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      if (state == ST_IDLE) mode_lat <= i_length_mode;
      if (state == ST_ACCUM && i_length_mode != mode_lat) err_q <= 1'b1;
      state <= row_last ? ST_IDLE : ST_ACCUM;
    end
  end

  // One-cycle marker of the most recent reset edge, used to keep o_ready low right after reset.
  always_ff @(posedge i_clk) begin
    rst_q <= i_rst;
  end

  acc_max_fifo #(.W(RW), .DEPTH(ROW_DEPTH)) u_row_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push_vld (in_acc),
    .push_dat ({i_in_flat, mode_eff, row_last}),
    .pop_rdy  (out_pop),
    .head_dat (row_head),
    .full     (row_full),
    .empty    (row_empty)
  );

  // The head row always belongs to the head group, so the group max retires with its last row.
  acc_max_fifo #(.W(DATA_W), .DEPTH(GRP_DEPTH)) u_grp_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push_vld (in_acc & row_last),
    .push_dat (acc_nxt),
    .pop_rdy  (out_pop & row_head[0]),
    .head_dat (grp_head),
    .full     (grp_full),
    .empty    (grp_empty)
  );

  assign o_in_byp          = o_valid ? row_head[RW-1 -: LW] : '0;
  assign o_length_mode_byp = o_valid ? row_head[MODE_W:1] : '0;
  assign o_last            = o_valid & row_head[0];
  assign o_max             = o_valid ? grp_head : '0;
  assign o_err_mode        = err_q;
endmodule

// File: tb/tb_acc_max_stream.sv
// Bench for acc_max_stream: directed scenarios plus randomized traffic, scored against a group-list model.
// Inputs are driven 1 ns after the rising edge; all observation happens on the falling edge.
// Random phase toggles i_ready and i_en to exercise backpressure and freeze behaviour.
module tb_acc_max_stream;
  localparam int DATA_W    = 16;
  localparam int LANES     = 4;
  localparam int MODE_W    = 4;
  localparam int ROW_DEPTH = 16;
  localparam int GRP_DEPTH = 4;
  localparam int LW        = LANES * DATA_W;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_en = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_ready = 1'b1;
  logic [DATA_W-1:0] i_max = '0;
  logic [MODE_W-1:0] i_length_mode = '0;
  logic [LW-1:0]     i_in_flat = '0;
  logic              o_ready, o_valid, o_last, o_err_mode;
  logic [DATA_W-1:0] o_max;
  logic [MODE_W-1:0] o_length_mode_byp;
  logic [LW-1:0]     o_in_byp;

  acc_max_stream #(
    .DATA_W(DATA_W), .LANES(LANES), .MODE_W(MODE_W),
    .ROW_DEPTH(ROW_DEPTH), .GRP_DEPTH(GRP_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_max(i_max), .i_length_mode(i_length_mode), .i_in_flat(i_in_flat),
    .o_valid(o_valid), .i_ready(i_ready), .o_max(o_max),
    .o_length_mode_byp(o_length_mode_byp), .o_in_byp(o_in_byp),
    .o_last(o_last), .o_err_mode(o_err_mode)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: collect whole groups, then emit every row with the group's max.
  typedef struct {
    logic [LW-1:0]     dat;
    logic [MODE_W-1:0] mode;
    int                mx;
    logic              last;
  } exp_t;

  exp_t              exp_q[$];
  logic [LW-1:0]     grp_dat_q[$];
  int                grp_max_q[$];
  bit                grp_open = 0;
  logic [MODE_W-1:0] grp_mode = '0;
  int                grp_n = 0;
  logic              exp_err = 1'b0;

  int   max_log[$];
  logic last_log[$];
  int   mode_log[$];
  int   n_out = 0;
  int   n_stall = 0;
  bit   count_stall = 0;
  bit   rnd_bp = 0;

  task automatic model_accept();
    int m;
    exp_t e;
    if (!grp_open) begin
      grp_open = 1;
      grp_mode = i_length_mode;
      grp_n    = (int'(i_length_mode) <= 2) ? 1 : int'(i_length_mode) - 1;
    end else if (i_length_mode != grp_mode) begin
      exp_err = 1'b1;
    end
    grp_dat_q.push_back(i_in_flat);
    grp_max_q.push_back(int'($signed(i_max)));
    if (grp_dat_q.size() == grp_n) begin
      m = grp_max_q[0];
      foreach (grp_max_q[k]) if (grp_max_q[k] > m) m = grp_max_q[k];
      foreach (grp_dat_q[k]) begin
        e.dat  = grp_dat_q[k];
        e.mode = grp_mode;
        e.mx   = m;
        e.last = (k == grp_n - 1);
        exp_q.push_back(e);
      end
      grp_dat_q.delete();
      grp_max_q.delete();
      grp_open = 0;
    end
  endtask

  // Monitor: compare DUT state first, then advance the model for the coming edge.
  always @(negedge i_clk) begin
    exp_t e;
    chk("err_mode", o_err_mode, exp_err);
    if (!i_en) chk("en_gate", {62'd0, o_ready, o_valid}, 64'd0);
    if (!o_valid) begin
      chk("mask_ctl", {43'd0, o_max, o_length_mode_byp, o_last}, 64'd0);
      chk("mask_dat", o_in_byp, 64'd0);
    end else if (i_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", o_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("out_dat", o_in_byp, e.dat);
        chk("out_mode", o_length_mode_byp, e.mode);
        chk("out_max", int'($signed(o_max)), e.mx);
        chk("out_last", o_last, e.last);
      end
      max_log.push_back(int'($signed(o_max)));
      last_log.push_back(o_last);
      mode_log.push_back(int'(o_length_mode_byp));
      n_out++;
    end
    if (count_stall && i_valid && !o_ready) n_stall++;
    if (i_rst) begin
      exp_q.delete();
      grp_dat_q.delete();
      grp_max_q.delete();
      grp_open = 0;
      exp_err  = 1'b0;
    end else if (i_valid && o_ready) begin
      model_accept();
    end
  end

  task automatic rnd_step();
    if (rnd_bp) begin
      i_ready = ($urandom_range(0, 9) < 7);
      i_en    = ($urandom_range(0, 15) != 0);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    rnd_step();
  endtask

  // Present one row and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send_row(input logic [MODE_W-1:0] m, input int mx, input logic [LW-1:0] d);
    i_valid       = 1'b1;
    i_length_mode = m;
    i_max         = DATA_W'(mx);
    i_in_flat     = d;
    for (int k = 0; k < 400; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        tick();
        i_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("send_timeout", o_ready, 1'b1);
    i_valid = 1'b0;
  endtask

  function automatic logic [LW-1:0] rnd_dat();
    return {$urandom, $urandom};
  endfunction

  function automatic int rnd_s16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic drain();
    rnd_bp  = 0;
    i_ready = 1'b1;
    i_en    = 1'b1;
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) tick();
    repeat (2) tick();
    chk("drain_empty", exp_q.size(), 0);
    @(negedge i_clk);
    chk("drain_idle", o_valid, 1'b0);
    tick();
  endtask

  task automatic clr_logs();
    max_log.delete();
    last_log.delete();
    mode_log.delete();
    n_out = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_max3[5];
    int exp_mode3[5];
    int exp_last3[5];
    int nrows;
    logic [MODE_W-1:0] gm;
    logic [MODE_W-1:0] rm;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", o_ready, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_err", o_err_mode, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    tick();

    // Mode 3: two rows, output appears one cycle after the closing accept
    clr_logs();
    send_row(4'd3, 500, rnd_dat());
    @(negedge i_clk);
    chk("t1_wait_valid", o_valid, 1'b0);
    tick();
    send_row(4'd3, 501, rnd_dat());
    @(negedge i_clk);
    chk("t1_latency", o_valid, 1'b1);
    tick();
    drain();
    chk("t1_count", n_out, 2);
    chk("t1_max0", max_log[0], 501);
    chk("t1_max1", max_log[1], 501);
    chk("t1_last0", last_log[0], 1'b0);
    chk("t1_last1", last_log[1], 1'b1);

    // Back-to-back groups with no input stall
    clr_logs();
    n_stall     = 0;
    count_stall = 1;
    for (int k = 0; k < 12; k++) send_row(4'd13, 100 + k, rnd_dat());
    send_row(4'd3, 2000, rnd_dat());
    send_row(4'd3, 2001, rnd_dat());
    count_stall = 0;
    drain();
    chk("t2_stall", n_stall, 0);
    chk("t2_count", n_out, 14);
    for (int k = 0; k < 12; k++) chk("t2_max_a", max_log[k], 111);
    chk("t2_last10", last_log[10], 1'b0);
    chk("t2_last11", last_log[11], 1'b1);
    chk("t2_max_b0", max_log[12], 2001);
    chk("t2_max_b1", max_log[13], 2001);

    // Bypass and mixed sequence
    clr_logs();
    send_row(4'd0, 999, rnd_dat());
    send_row(4'd4, 100, rnd_dat());
    send_row(4'd4, 101, rnd_dat());
    send_row(4'd4, 102, rnd_dat());
    send_row(4'd1, 888, rnd_dat());
    drain();
    exp_max3  = '{999, 102, 102, 102, 888};
    exp_mode3 = '{0, 4, 4, 4, 1};
    exp_last3 = '{1, 0, 0, 1, 1};
    chk("t3_count", n_out, 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_max", max_log[k], exp_max3[k]);
      chk("t3_mode", mode_log[k], exp_mode3[k]);
      chk("t3_last", last_log[k], exp_last3[k][0]);
    end

    // Signed values with output held off until both FIFOs fill
    clr_logs();
    i_ready = 1'b0;
    send_row(4'd4, -5, rnd_dat());
    send_row(4'd4, -300, rnd_dat());
    send_row(4'd4, -2, rnd_dat());
    for (int k = 0; k < 4; k++) send_row(4'd5, rnd_s16(), rnd_dat());
    for (int k = 0; k < 4; k++) send_row(4'd5, rnd_s16(), rnd_dat());
    for (int k = 0; k < 5; k++) send_row(4'd6, rnd_s16(), rnd_dat());
    @(negedge i_clk);
    chk("t4_full_ready", o_ready, 1'b0);
    chk("t4_full_valid", o_valid, 1'b1);
    tick();
    drain();
    chk("t4_count", n_out, 16);
    for (int k = 0; k < 3; k++) chk("t4_neg_max", max_log[k], -2);

    // Mode mismatch inside a mode 5 group
    clr_logs();
    send_row(4'd5, 10, rnd_dat());
    send_row(4'd3, 40, rnd_dat());
    @(negedge i_clk);
    chk("t5_err_set", o_err_mode, 1'b1);
    tick();
    send_row(4'd5, 20, rnd_dat());
    send_row(4'd5, 30, rnd_dat());
    drain();
    chk("t5_count", n_out, 4);
    chk("t5_last3", last_log[3], 1'b1);
    chk("t5_mode1", mode_log[1], 5);
    chk("t5_max", max_log[3], 40);
    chk("t5_err_hold", o_err_mode, 1'b1);

    // Reset in the middle of a mode 6 group
    clr_logs();
    send_row(4'd6, 50, rnd_dat());
    send_row(4'd6, 60, rnd_dat());
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("t6_rst_valid", o_valid, 1'b0);
    chk("t6_rst_ready", o_ready, 1'b0);
    chk("t6_rst_err", o_err_mode, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("t6_post_rst_ready", o_ready, 1'b0);
    chk("t6_post_rst_valid", o_valid, 1'b0);
    tick();
    send_row(4'd3, 7, rnd_dat());
    send_row(4'd3, 9, rnd_dat());
    drain();
    chk("t6_count", n_out, 2);
    chk("t6_max0", max_log[0], 9);
    chk("t6_max1", max_log[1], 9);

    // Randomized traffic with backpressure and enable freezes
    clr_logs();
    rnd_bp = 1;
    for (int g = 0; g < 40; g++) begin
      gm    = MODE_W'($urandom_range(0, 15));
      nrows = (int'(gm) <= 2) ? 1 : int'(gm) - 1;
      for (int r = 0; r < nrows; r++) begin
        rm = ($urandom_range(0, 9) == 0) ? MODE_W'($urandom_range(0, 15)) : gm;
        send_row(rm, rnd_s16(), rnd_dat());
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/acc_max_stream.md
# acc_max_stream

Parametrised successor to the row-group max accumulator in the softmax approximation path. It receives rows of LANES×DATA_W data, each with a precomputed per-row partial max. It buffers every row of a group and computes the signed running max across the group. Once the group's last row arrives, it re-emits each buffered row paired with the final group max. It adds ready/valid backpressure on both sides, generic widths and depths, a last-row marker, and a sticky mode-consistency error.

## Interface
Parameters:
- DATA_W, 16, element and max width (signed two's complement)
- LANES, 64, elements per row
- MODE_W, 4, width of length mode
- ROW_DEPTH, 16, row FIFO entries; must be ≥ 2^MODE_W−2
- GRP_DEPTH, 4, group-max FIFO entries

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  global enable; low freezes all state, forces o_ready=0 and o_valid=0
- i_valid  in  1  upstream row valid
- o_ready  out  1  upstream ready
- i_max  in  DATA_W  per-row partial max
- i_length_mode  in  MODE_W  group length mode
- i_in_flat  in  LANES*DATA_W  row data
- o_valid  out  1  downstream row valid
- i_ready  in  1  downstream ready
- o_max  out  DATA_W  final group max for the emitted row
- o_length_mode_byp  out  MODE_W  mode latched for the row's group
- o_in_byp  out  LANES*DATA_W  row data, unchanged
- o_last  out  1  emitted row is the last row of its group
- o_err_mode  out  1  sticky; set when a row's mode differs from its group's latched mode

## Operation
- Rows per group (N): mode ≤ 2 → 1 (bypass); otherwise mode−1. Maximum N is 2^MODE_W−2.
- Accept: i_en & i_valid & o_ready.
  - o_ready = i_en & !row_full & !grp_full.
  - No pass-through when full; a pop and push in the same cycle do not free space for that cycle.
- Input FSM, states IDLE and ACCUM:
  - IDLE, accept: latch mode, compute N, set acc=i_max, cnt=1. If N=1, push acc to the group FIFO and stay in IDLE; otherwise go to ACCUM.
  - ACCUM, accept: acc = signed max(acc, i_max), cnt+1. When cnt reaches N, push the result to the group FIFO and return to IDLE.
  - ACCUM, accept with i_length_mode ≠ latched mode: set o_err_mode. The latched mode still governs N; the row is accepted normally.
- Row FIFO entry: {data, latched mode, last flag}, pushed on every accept. The last flag is 1 when cnt reaches N.
- Output uses first-word fall-through heads:
  - o_valid = i_en & row FIFO non-empty & group FIFO non-empty.
  - Head row always belongs to the head group.
- Pop: o_valid & i_ready pops the row FIFO. If the popped row's last flag is 1, the group FIFO pops in the same cycle.
- Masking: when o_valid=0, the outputs o_max, o_in_byp, o_length_mode_byp and o_last all read 0.
- o_err_mode clears only on reset.

## Timing
- Reset (i_rst high at a clock edge):
  - Both FIFOs empty, FSM to IDLE, acc=0, cnt=0, o_err_mode=0.
  - o_ready=0 and o_valid=0 in the cycle after the reset edge and while i_rst stays high.
  - A partial group is discarded.
- Latency: the last row of a group accepted at edge t gives o_valid=1 in cycle t+1. A bypass row also gives o_valid=1 in cycle t+1.
- Earlier rows of a group wait in the row FIFO until the group closes.
- Throughput: 1 row/cycle in and 1 row/cycle out when neither FIFO is full.
- A group of 14 rows followed immediately by another group streams without bubbles given ROW_DEPTH ≥ 16 and no output stall.
- i_en low mid-group: acc, cnt, FSM and FIFO contents are held; the group resumes when i_en returns high.

## Test plan
- Mode 3, i_max=500 then 501, no stall:
  - Two outputs, both o_max=501.
  - o_last=0, then 1.
  - First o_valid one cycle after the second accept.
- Back-to-back groups, mode 13 (rows 100..111) then mode 3 (2000, 2001):
  - 12 outputs with o_max=111, o_last on the 12th.
  - Then 2 outputs with o_max=2001.
  - No input stall.
- Bypass/mixed sequence, mode 0 (999), mode 4 (100, 101, 102), mode 1 (888):
  - Outputs in order: 999; 102, 102, 102; 888.
  - Mode carried through o_length_mode_byp.
- Signed values and backpressure:
  - Mode 4 with i_max −5, −300, −2; expect o_max=−2 on all three rows.
  - i_ready held 0 until both FIFOs fill; o_ready must drop.
  - Nothing is lost or duplicated after release.
- Mode mismatch: mode 5 group where the second row carries mode 3:
  - o_err_mode=1 and stays high.
  - The group still closes after 4 rows.
- Reset mid-operation: assert i_rst after 2 rows of a mode 6 group:
  - o_valid=0 and the FIFOs are empty.
  - A following mode 3 group (7, 9) yields o_max=9 twice.
